// File: rtl/led_effect_scheduler.sv
// Arbitrated single-LED effect engine: prescaler, PWM period counter, owner arbitration at period
// boundaries and off/solid/breath/blink duty generation. Define LED_GAMMA_EN for squared breath duty.
module led_effect_scheduler #(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned RAMP_PERIODS  = 4,
  parameter int unsigned BLINK_PERIODS = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          req_i,
  input  logic [5:0]          req_mode_i,
  output logic [2:0]          grant_o,
  output logic                busy_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                period_start_o,
  output logic                pwm_o
);

  localparam int unsigned TickW  = $clog2(CLK_DIV);
  localparam int unsigned RampW  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int unsigned BlinkW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [TickW-1:0]    TickLast  = TickW'(CLK_DIV - 1);
  localparam logic [RampW-1:0]    RampLast  = RampW'(RAMP_PERIODS - 1);
  localparam logic [BlinkW-1:0]   BlinkLast = BlinkW'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] DutyMax   = '1;

  typedef enum logic [1:0] {ModeOff, ModeSolid, ModeBreath, ModeBlink} mode_e;

  logic [TickW-1:0]    tick_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [2:0]          grant_q, grant_d;
  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                dir_down_q, dir_down_d;
  logic [RampW-1:0]    rdiv_q, rdiv_d;
  logic [BlinkW-1:0]   bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic                period_start_q;
  logic                pwm_q;

  logic                tick;
  logic                period_end;
  logic [2:0]          new_grant;
  mode_e               new_mode;
  logic                restart;
  logic [PWM_BITS-1:0] duty;

  assign tick       = (tick_cnt_q == TickLast);
  assign period_end = tick && (pwm_cnt_q == DutyMax);

  always_comb begin
    new_grant = 3'b000;
    new_mode  = ModeOff;
    if (req_i[2]) begin
      new_grant = 3'b100;
      new_mode  = mode_e'(req_mode_i[5:4]);
    end else if (req_i[1]) begin
      new_grant = 3'b010;
      new_mode  = mode_e'(req_mode_i[3:2]);
    end else if (req_i[0]) begin
      new_grant = 3'b001;
      new_mode  = mode_e'(req_mode_i[1:0]);
    end
  end

  // A different owner or a mode change by the same owner restarts the effect from its origin.
  assign restart = (new_grant != grant_q) || (new_mode != mode_q);

  always_comb begin
    grant_d    = grant_q;
    mode_d     = mode_q;
    ramp_d     = ramp_q;
    dir_down_d = dir_down_q;
    rdiv_d     = rdiv_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    if (period_end) begin
      grant_d = new_grant;
      mode_d  = new_mode;
      if (restart) begin
        ramp_d     = '0;
        dir_down_d = 1'b0;
        rdiv_d     = '0;
        bcnt_d     = '0;
        phase_d    = 1'b1;
      end else begin
        case (mode_q)
          ModeBreath: begin
            if (rdiv_q == RampLast) begin
              rdiv_d = '0;
              if (!dir_down_q) begin
                ramp_d     = ramp_q + PWM_BITS'(1);
                dir_down_d = (ramp_q == DutyMax - PWM_BITS'(1));
              end else begin
                ramp_d     = ramp_q - PWM_BITS'(1);
                dir_down_d = (ramp_q != PWM_BITS'(1));
              end
            end else begin
              rdiv_d = rdiv_q + RampW'(1);
            end
          end
          ModeBlink: begin
            if (bcnt_q == BlinkLast) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end else begin
              bcnt_d = bcnt_q + BlinkW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LED_GAMMA_EN
  localparam int unsigned SqW = 2 * PWM_BITS;
  logic [SqW-1:0] ramp_sq;
  assign ramp_sq = SqW'(ramp_q) * SqW'(ramp_q);
`endif

  always_comb begin
    duty = '0;
    if (grant_q != 3'b000) begin
      case (mode_q)
        ModeSolid:  duty = DutyMax;
`ifdef LED_GAMMA_EN
        ModeBreath: duty = ramp_sq[SqW-1:PWM_BITS];
`else
        ModeBreath: duty = ramp_q;
`endif
        ModeBlink:  duty = phase_q ? DutyMax : '0;
        default:    duty = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q     <= '0;
      pwm_cnt_q      <= '0;
      grant_q        <= 3'b000;
      mode_q         <= ModeOff;
      ramp_q         <= '0;
      dir_down_q     <= 1'b0;
      rdiv_q         <= '0;
      bcnt_q         <= '0;
      phase_q        <= 1'b1;
      period_start_q <= 1'b0;
      pwm_q          <= 1'b0;
    end else begin
      tick_cnt_q     <= tick ? '0 : tick_cnt_q + TickW'(1);
      if (tick) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      grant_q        <= grant_d;
      mode_q         <= mode_d;
      ramp_q         <= ramp_d;
      dir_down_q     <= dir_down_d;
      rdiv_q         <= rdiv_d;
      bcnt_q         <= bcnt_d;
      phase_q        <= phase_d;
      period_start_q <= period_end;
      pwm_q          <= (pwm_cnt_q < duty);
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = (grant_q != 3'b000);
  assign duty_o         = duty;
  assign period_start_o = period_start_q;
  assign pwm_o          = pwm_q;

endmodule

// File: doc/led_effect_scheduler.md
# led_effect_scheduler

Shares the alarm board's single status LED between three effect requesters (idle indicator, snooze, alarm) and sequences the chosen effect: off, solid, breathing ramp or blink. Contains the tick prescaler, the PWM period counter and the duty-ramp engine, so it replaces a free-running breathing generator with an arbitrated, mode-driven one. Sits between the alarm FSM and the LED pin.

## Interface
- CLK_DIV, 50: clk cycles per PWM tick (≥2).
- PWM_BITS, 8: duty/counter width; PWM period = 2^PWM_BITS ticks.
- RAMP_PERIODS, 4: PWM periods per breathing duty step (≥1).
- BLINK_PERIODS, 128: PWM periods per blink half-phase (≥1).

- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- req  in  3  level requests; bit 2 highest priority (alarm), bit 0 lowest (idle)
- req_mode  in  6  2-bit mode per requester, [2i+1:2i] for req[i]; 00 OFF, 01 SOLID, 10 BREATH, 11 BLINK
- grant  out  3  one-hot current owner, 000 when none
- busy  out  1  grant != 000
- duty  out  PWM_BITS  effective duty currently applied
- period_start  out  1  one-clk pulse at each PWM period boundary
- pwm  out  1  registered LED drive

## Operation
- Prescaler: tick_cnt 0..CLK_DIV-1; tick asserted when tick_cnt==CLK_DIV-1.
- pwm_cnt increments on tick, wraps 2^PWM_BITS-1 -> 0. period_end = tick && pwm_cnt==max. period_start = period_end delayed 1 clk.
- Arbitration only on period_end: grant <= highest set req bit (none -> 000). Owner mode latched at the same edge. Never preempts mid-period.
- Effect restart: if the new grant or latched mode differs from the previous, effect state resets (ramp=0, dir=up, blink_cnt=0, phase=1).
- OFF: duty 0. SOLID: duty max (2^PWM_BITS-1). No grant: duty 0.
- BREATH: every RAMP_PERIODS period_ends, step ramp. Up: ramp==max-1 -> ramp=max, dir=down; else +1. Down: ramp==1 -> ramp=0, dir=up; else -1. Triangle 0..max..0 with no endpoint dwell.
- BLINK: blink_cnt counts period_ends; at BLINK_PERIODS-1 wraps to 0 and toggles phase. duty = phase ? max : 0.
- pwm <= (pwm_cnt < duty) every clk.
- Requester dropping req keeps grant until the next period_end.

## Timing
- Reset (sync, next edge): pwm 0, grant 000, busy 0, duty 0, period_start 0, all counters/ramp 0, dir up, phase 1. Applies mid-effect identically.
- Period = CLK_DIV * 2^PWM_BITS clocks; first period_end at clock CLK_DIV*2^PWM_BITS after rst deassert.
- Grant, busy, mode, duty update on the period_end edge; pwm reflects new duty from the following clk (1-clk latency).
- Simultaneous req change and period_end: sampled value at that edge decides.
- Mode change by current owner: treated like a new grant (effect restart) at period_end.

## Configuration
- LED_GAMMA_EN defined: in BREATH only, duty = (ramp*ramp) >> PWM_BITS (2*PWM_BITS-bit product, truncated). Other modes unchanged.
- Undefined: duty = ramp in BREATH; no multiplier.

## Test plan
Params CLK_DIV=2, PWM_BITS=3, RAMP_PERIODS=1, BLINK_PERIODS=2 (period 16 clks).
- Reset/idle: rst held 5 clks then released, req=000 -> pwm, grant, busy, duty stay 0; period_start pulses every 16 clks.
- SOLID: req=001, mode0=01 from reset -> grant 001 at clk 16; duty 7; pwm high 14 of every 16 clks.
- BREATH: req=001, mode0=10 -> duty per period 0,1,..,7,6,..,1,0,1; pwm high-count per period = 2*duty.
- Priority: req0 SOLID owned, req[2] BLINK raised mid-period -> grant stays 001 until period_end, then 100; duty 7,7,0,0,7 per period; drop req[2] -> 001, duty 7 at next period_end.
- Reset mid-breath at duty 5 -> all outputs 0 next clk; grant re-acquired at 16 clks after release, ramp restarts at 0.
- LED_GAMMA_EN: breath ramp 4 -> duty 2, ramp 7 -> duty 6; without macro duty 4 and 7.
